// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited in-order instruction memory requests,
// a response FIFO toward decode, and redirect handling that discards stale responses.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        PCSel,
    input  logic [31:0] pc_target_i
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   hpc_q, hpc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic          run_q, run_d;

    logic          grant, rsp, discard, push, fire, redirect, pop;
    logic [31:0]   target;

    assign imem_req     = run_q && ((32'(out_cnt_q) + 32'(cnt_q)) < DEPTH);
    assign imem_addr    = fpc_q;
    assign inst_o       = mem_q[rd_ptr_q];
    assign pc_o         = hpc_q;
    assign inst_valid_o = (cnt_q != '0);

    always_comb begin
        target   = pc_target_i & ~32'd3;
        grant    = imem_req & imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp      = imem_rvalid & (out_cnt_q != '0);
        discard  = rsp & (drop_cnt_q != '0);
        push     = rsp & ~discard;
        fire     = inst_valid_o & inst_ready_i;
        redirect = fire & PCSel;
        pop      = fire & ~PCSel;

        run_d     = 1'b1;
        out_cnt_d = out_cnt_q + CW'(grant) - CW'(rsp);

        // Every response still owed after this edge belongs to the old stream,
        // so the already-pending drops are contained in out_cnt_d.
        if (redirect) begin
            drop_cnt_d = out_cnt_d;
        end else begin
            drop_cnt_d = drop_cnt_q - CW'(discard);
        end

        if (redirect) begin
            fpc_d = target;
        end else if (grant) begin
            fpc_d = fpc_q + 32'd4;
        end else begin
            fpc_d = fpc_q;
        end

        if (redirect) begin
            hpc_d = target;
        end else if (pop) begin
            hpc_d = hpc_q + 32'd4;
        end else begin
            hpc_d = hpc_q;
        end

        mem_d = mem_q;
        if (push && !redirect) begin
            mem_d[wr_ptr_q] = imem_rdata;
        end

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            hpc_q      <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_q      <= '{default: '0};
            run_q      <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            hpc_q      <= hpc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
            run_q      <= run_d;
        end
    end

    push_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (cnt_q == CW'(DEPTH))));

endmodule
